ram_rd_streamer: RTL and testbench
==================================

# ram_rd_streamer

Read-side initiator for the dual-interface 2D RAM block. On a start command it issues `len` consecutive read addresses beginning at `base_addr` on the RAM read port. It collects the fixed-latency read data and presents it as a valid/ready stream with a last flag. A small credit-controlled FIFO absorbs downstream backpressure, because the RAM read port has no stall.

## Interface
- `DEPTH`, 32: RAM word count; must be a power of 2; `ADDR_LEN = $clog2(DEPTH)` (localparam).
- `WIDTH`, 32: data word width.
- `FIFO_DEPTH`, 4: output buffer entries; power of 2, ≥ 2.
- `MAX_LEN`, 256: largest transfer length; `LEN_W = $clog2(MAX_LEN+1)` (localparam).

- `clk`  in  1  sole clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin transfer; sampled only in IDLE.
- `base_addr`  in  ADDR_LEN  first word address; sampled with `start`.
- `len`  in  LEN_W  word count; sampled with `start`.
- `stride`  in  ADDR_LEN  address increment; sampled with `start`; present only with `RAM_RD_STRIDE_EN`.
- `busy`  out  1  high when the state is not IDLE.
- `done`  out  1  one-cycle pulse at transfer completion.
- `ram_valid_addr`  out  1  read request; connects to the RAM `valid_addr_ps`.
- `ram_r_addr`  out  ADDR_LEN  read address.
- `ram_r_data`  in  WIDTH  RAM read data.
- `ram_valid_data`  in  1  RAM read data valid.
- `m_valid`  out  1  stream data valid.
- `m_data`  out  WIDTH  stream data.
- `m_last`  out  1  final word of the transfer.
- `m_ready`  in  1  downstream accept.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: issuing addresses.
  - DRAIN: all addresses issued; waiting for the FIFO to empty.
- IDLE → RUN on `start` with `len` ≠ 0. Latches the base address, length and step, and clears the issue and accept counters.
- IDLE with `start` and `len` = 0: stays in IDLE and pulses `done` the next cycle. No reads are issued.
- `start` outside IDLE is ignored.
- Issue condition: `ram_valid_addr` = RUN && `issued` < `len` && (`fifo_count` + `inflight`) < FIFO_DEPTH.
  - `inflight` = request issued in the previous cycle.
  - This credit rule guarantees the FIFO never overflows. No RAM response is ever dropped.
- Address generation: `ram_r_addr` = (base + k·step) mod DEPTH for the k-th request. The address wraps naturally at ADDR_LEN bits. `step` = 1 without the macro.
- RUN → DRAIN when `issued` reaches `len` on an issuing cycle.
- DRAIN → IDLE on the handshake (`m_valid` && `m_ready`) of the word with `m_last`. `done` pulses in the following cycle.
- FIFO write: every cycle `ram_valid_data` = 1 while not in IDLE. `ram_valid_data` is ignored in IDLE, which discards stale responses after reset.
- `m_last` = FIFO head is word `len`-1. It is tracked by the accept counter: `accepted` = `len`-1 while `m_valid`.
- `m_data` and `m_valid` are held stable while `m_valid` && !`m_ready`.
- Simultaneous FIFO push and pop: count is unchanged, and both operations take effect.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_valid_addr`=0, `ram_r_addr`=0, `m_valid`=0, `m_last`=0, `m_data`=0. FIFO empty, counters 0, state IDLE.
- Reset asserted mid-transfer: immediate abort with no `done` pulse. The outstanding RAM response is discarded.
- RAM read latency is exactly 1 cycle.
- Start to first stream word:
  - `start` sampled at edge T.
  - `ram_valid_addr` high in cycle T+1.
  - `ram_valid_data` high in T+2.
  - `m_valid` high in T+3.
- With `m_ready` held high: one word per cycle sustained. Last word in cycle T+2+`len`. `done` in T+3+`len`.
- With `m_ready` low: issue stalls once FIFO_DEPTH words are buffered or in flight. Issue resumes one cycle after a pop.

## Configuration
- `RAM_RD_STRIDE_EN` defined: the `stride` port exists. Step = `stride`, and `stride` = 0 rereads `base_addr` `len` times.
- Not defined: the port is absent and the step is fixed at 1.

## Structure
- Package `ram_rd_pkg`: the state enum `rd_state_t`.
- Sub-module `ram_rd_fifo`: synchronous FIFO with async active-low reset, parameterised width and depth, exposing `count`, `empty` and `full`.

## Test plan
- Base 0, len 4, `m_ready`=1, RAM preloaded with address values → `m_data` 0,1,2,3 in cycles T+3..T+6. `m_last` only on 3. `done` at T+7.
- Base 30, len 4, DEPTH 32 → addresses 30,31,0,1 issued. Data appears in that order.
- Len 8, `m_ready` low for 10 cycles after `start` → at most 4 requests issued. No data lost. All 8 words arrive in order once `m_ready` rises.
- Len 0 → no `ram_valid_addr`. `busy` stays 0. `done` pulses in cycle T+1.
- `rst_n` pulsed low at the third stream word of len 6, followed by `start` len 2 → all outputs at reset values immediately. The new transfer delivers exactly 2 words with no stale data.
- With `RAM_RD_STRIDE_EN`: base 1, stride 3, len 3 → addresses 1,4,7.

Source files
------------

// File: rtl/ram_rd_pkg.sv
// Shared types for the RAM read streamer.
package ram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO used as the output skid buffer of the read streamer.
module ram_rd_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage, pointers and occupancy; pointers wrap because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ram_rd_streamer.sv
// Read-side initiator: issues a run of RAM reads and streams the data out
// through a credit-protected FIFO. Optional macro RAM_RD_STRIDE_EN adds a
// programmable address stride; without it the step is fixed at 1.
module ram_rd_streamer
  import ram_rd_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_LEN    = 256,
  localparam int unsigned ADDR_LEN  = $clog2(DEPTH),
  localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_LEN-1:0] base_addr,
  input  logic [LEN_W-1:0]    len,
`ifdef RAM_RD_STRIDE_EN
  input  logic [ADDR_LEN-1:0] stride,
`endif
  output logic                busy,
  output logic                done,
  output logic                ram_valid_addr,
  output logic [ADDR_LEN-1:0] ram_r_addr,
  input  logic [WIDTH-1:0]    ram_r_data,
  input  logic                ram_valid_data,
  output logic                m_valid,
  output logic [WIDTH-1:0]    m_data,
  output logic                m_last,
  input  logic                m_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  rd_state_t           state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    accepted_q, accepted_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic                issue_q, issue_d;
  logic                done_q, done_d;
  logic [ADDR_LEN-1:0] step_c;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_empty;
  logic                fifo_full;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    count_nxt_c;
  logic [CNT_W:0]      credit_c;

`ifdef RAM_RD_STRIDE_EN
  logic [ADDR_LEN-1:0] step_q, step_d;
  assign step_c = step_q;
`else
  assign step_c = ADDR_LEN'(1);
`endif

  // Responses arriving in IDLE are stale (e.g. in flight across a reset) and dropped.
  assign fifo_push = ram_valid_data && (state_q != ST_IDLE) && !fifo_full;
  assign fifo_pop  = m_valid && m_ready;

  // Occupancy next cycle plus the request issued this cycle still owed by the RAM.
  assign count_nxt_c = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
  assign credit_c    = {1'b0, count_nxt_c} + (CNT_W + 1)'(issue_q);

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign ram_valid_addr = issue_q;
  assign ram_r_addr     = addr_q;
  assign m_valid        = !fifo_empty;
  assign m_last         = m_valid && (accepted_q == len_q - LEN_W'(1));

  // Next-state logic; the issue strobe is precomputed from next-cycle values so it leaves a flop.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    addr_d     = addr_q;
    done_d     = 1'b0;
    issue_d    = 1'b0;
`ifdef RAM_RD_STRIDE_EN
    step_d     = step_q;
`endif

    if (issue_q) begin
      issued_d = issued_q + LEN_W'(1);
      addr_d   = addr_q + step_c;
    end
    if (fifo_pop) begin
      accepted_d = accepted_q + LEN_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d    = ST_RUN;
            len_d      = len;
            issued_d   = '0;
            accepted_d = '0;
            addr_d     = base_addr;
`ifdef RAM_RD_STRIDE_EN
            step_d     = stride;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (issue_q && (issued_q + LEN_W'(1) == len_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_pop && m_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    issue_d = (state_d == ST_RUN) && (issued_d < len_d) &&
              (credit_c < (CNT_W + 1)'(FIFO_DEPTH));
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      addr_q     <= '0;
      issue_q    <= 1'b0;
      done_q     <= 1'b0;
`ifdef RAM_RD_STRIDE_EN
      step_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      done_q     <= done_d;
`ifdef RAM_RD_STRIDE_EN
      step_q     <= step_d;
`endif
    end
  end

  ram_rd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (ram_r_data),
    .pop_i   (fifo_pop),
    .rdata_o (m_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Directed bench for ram_rd_streamer with a 1-cycle-latency RAM model.
module tb_ram_rd_streamer;

  localparam int unsigned AW    = 5;
  localparam int unsigned LEN_W = 9;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic [LEN_W-1:0] len;
`ifdef RAM_RD_STRIDE_EN
  logic [AW-1:0]    stride;
`endif
  logic             busy;
  logic             done;
  logic             ram_valid_addr;
  logic [AW-1:0]    ram_r_addr;
  logic [31:0]      ram_r_data;
  logic             ram_valid_data;
  logic             m_valid;
  logic [31:0]      m_data;
  logic             m_last;
  logic             m_ready;

  logic [31:0]      mem [32];

  int checks;
  int errors;

  typedef struct {
    logic [AW-1:0]        base;
    logic [AW-1:0]        step;
    int                   n;
    logic [7:0][AW-1:0]   addr;
  } vec_t;

  vec_t vecs[$];

  ram_rd_streamer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .base_addr      (base_addr),
    .len            (len),
`ifdef RAM_RD_STRIDE_EN
    .stride         (stride),
`endif
    .busy           (busy),
    .done           (done),
    .ram_valid_addr (ram_valid_addr),
    .ram_r_addr     (ram_r_addr),
    .ram_r_data     (ram_r_data),
    .ram_valid_data (ram_valid_data),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_last         (m_last),
    .m_ready        (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: fixed 1-cycle read latency, not affected by the streamer reset.
  always @(posedge clk) begin
    ram_valid_data <= ram_valid_addr;
    ram_r_data     <= mem[ram_r_addr];
  end

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    return 32'h100 + 32'(a);
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_rva"}, ram_valid_addr, 1'b0);
    chkw({tag, "_raddr"}, 32'(ram_r_addr), 32'd0);
    chk1({tag, "_mvalid"}, m_valid, 1'b0);
    chk1({tag, "_mlast"}, m_last, 1'b0);
    chkw({tag, "_mdata"}, m_data, 32'd0);
  endtask

  // One transfer with m_ready high; cycle c is the c-th cycle after the start edge.
  task automatic run_vec(input vec_t v, input string tag);
    logic exp_rva, exp_mv;
    @(negedge clk);
    m_ready   = 1'b1;
    start     = 1'b1;
    base_addr = v.base;
    len       = LEN_W'(v.n);
`ifdef RAM_RD_STRIDE_EN
    stride    = v.step;
`endif
    @(posedge clk);
    for (int c = 1; c <= v.n + 4; c++) begin
      @(negedge clk);
      start   = 1'b0;
      exp_rva = (c <= v.n);
      exp_mv  = (c >= 3) && (c <= v.n + 2);
      chk1($sformatf("%s_c%0d_busy", tag, c), busy, (c <= v.n + 2));
      chk1($sformatf("%s_c%0d_done", tag, c), done, (c == v.n + 3));
      chk1($sformatf("%s_c%0d_rva", tag, c), ram_valid_addr, exp_rva);
      if (exp_rva)
        chkw($sformatf("%s_c%0d_raddr", tag, c), 32'(ram_r_addr), 32'(v.addr[c-1]));
      chk1($sformatf("%s_c%0d_mvalid", tag, c), m_valid, exp_mv);
      chk1($sformatf("%s_c%0d_mlast", tag, c), m_last, exp_mv && (c == v.n + 2));
      if (exp_mv)
        chkw($sformatf("%s_c%0d_mdata", tag, c), m_data, word_of(v.addr[c-3]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

  initial begin
    int n_iss;
    int got;
    logic saw_done;
    vec_t rv;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b0;
`ifdef RAM_RD_STRIDE_EN
    stride    = '0;
`endif
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);

    vecs.push_back('{base: 5'd0,  step: 5'd1, n: 4,
                     addr: {5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd2, 5'd1, 5'd0}});
    vecs.push_back('{base: 5'd30, step: 5'd1, n: 4,
                     addr: {5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd31, 5'd30}});
    vecs.push_back('{base: 5'd5,  step: 5'd1, n: 1,
                     addr: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5}});
    vecs.push_back('{base: 5'd28, step: 5'd1, n: 8,
                     addr: {5'd3, 5'd2, 5'd1, 5'd0, 5'd31, 5'd30, 5'd29, 5'd28}});
`ifdef RAM_RD_STRIDE_EN
    vecs.push_back('{base: 5'd1,  step: 5'd3, n: 3,
                     addr: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd4, 5'd1}});
    vecs.push_back('{base: 5'd9,  step: 5'd0, n: 3,
                     addr: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd9, 5'd9}});
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven transfers
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Zero-length start: done only, no reads
    @(negedge clk);
    start = 1'b1;
    len   = '0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk1("len0_done", done, 1'b1);
    chk1("len0_busy", busy, 1'b0);
    chk1("len0_rva", ram_valid_addr, 1'b0);
    @(negedge clk);
    chk1("len0_done_after", done, 1'b0);
    chk1("len0_busy_after", busy, 1'b0);
    chk1("len0_rva_after", ram_valid_addr, 1'b0);

    // Backpressure: len 8 with m_ready low for 10 cycles
    @(negedge clk);
    m_ready   = 1'b0;
    start     = 1'b1;
    base_addr = 5'd0;
    len       = LEN_W'(8);
`ifdef RAM_RD_STRIDE_EN
    stride    = 5'd1;
`endif
    n_iss = 0;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (ram_valid_addr) n_iss++;
      if (m_valid) chkw($sformatf("bp_stall_c%0d_mdata", c), m_data, 32'h100);
    end
    chkw("bp_issued_while_stalled", 32'(n_iss), 32'd4);
    chk1("bp_mvalid_stalled", m_valid, 1'b1);
    chk1("bp_busy_stalled", busy, 1'b1);
    m_ready  = 1'b1;
    got      = 0;
    saw_done = 1'b0;
    for (int c = 0; c < 40 && !saw_done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (ram_valid_addr) n_iss++;
      end
      if (done) saw_done = 1'b1;
      if (m_valid) begin
        chkw($sformatf("bp_word%0d_data", got), m_data, 32'h100 + 32'(got));
        chk1($sformatf("bp_word%0d_last", got), m_last, (got == 7));
        got++;
      end
    end
    chkw("bp_words", 32'(got), 32'd8);
    chkw("bp_total_issued", 32'(n_iss), 32'd8);
    chk1("bp_done_seen", saw_done, 1'b1);

    // Reset at the third stream word of a len-6 transfer
    @(negedge clk);
    start     = 1'b1;
    base_addr = 5'd0;
    len       = LEN_W'(6);
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk1("abort_pre_mvalid", m_valid, 1'b1);
    chkw("abort_pre_mdata", m_data, 32'h102);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    #2;
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk1($sformatf("abort_idle_c%0d_mvalid", c), m_valid, 1'b0);
      chk1($sformatf("abort_idle_c%0d_busy", c), busy, 1'b0);
      chk1($sformatf("abort_idle_c%0d_done", c), done, 1'b0);
    end
    rv = '{base: 5'd10, step: 5'd1, n: 2,
           addr: {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd11, 5'd10}};
    run_vec(rv, "post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
